// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// Operands are converted to magnitudes at capture and the sign is restored on the final iteration.
module mul_iter #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1,
   parameter int RESULT_WIDTH   = 2 * WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        A,
   input  logic [WIDTH-1:0]        B,
   input  logic                    a_signed,
   input  logic                    b_signed,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [RESULT_WIDTH-1:0] mul_result
);

   localparam int ITER = WIDTH / BITS_PER_CYCLE;
   localparam int CW   = $clog2(ITER + 1);
   localparam int PW   = 2 * WIDTH;
   localparam int FW   = (RESULT_WIDTH > PW) ? RESULT_WIDTH : PW;

   if (WIDTH < 2 || !(BITS_PER_CYCLE inside {1, 2, 4}) || (WIDTH % BITS_PER_CYCLE) != 0)
   begin : g_bad_params
      $error("mul_iter: illegal WIDTH/BITS_PER_CYCLE combination");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state, state_nxt;
   logic [PW-1:0]           mcand;
   logic [PW-1:0]           acc;
   logic [PW-1:0]           acc_nxt;
   logic [WIDTH-1:0]        mplier;
   logic [CW-1:0]           iter;
   logic                    res_neg;
   logic [RESULT_WIDTH-1:0] result;
   logic                    a_neg, b_neg;
   logic [WIDTH-1:0]        mag_a, mag_b;
   logic [FW-1:0]           mag_w, signed_w;
   logic                    last;

   always_comb begin
      a_neg    = a_signed & A[WIDTH-1];
      b_neg    = b_signed & B[WIDTH-1];
      mag_a    = a_neg ? (~A + WIDTH'(1)) : A;
      mag_b    = b_neg ? (~B + WIDTH'(1)) : B;
      acc_nxt  = acc + mcand * PW'(mplier[BITS_PER_CYCLE-1:0]);
      last     = (iter == CW'(1));
      // Negate at the wider of product/result width so a wide RESULT_WIDTH is sign-extended correctly
      mag_w    = FW'(acc_nxt);
      signed_w = res_neg ? (~mag_w + FW'(1)) : mag_w;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         acc     <= '0;
         mplier  <= '0;
         iter    <= '0;
         res_neg <= 1'b0;
         result  <= '0;
      end else if (flush) begin
         mcand   <= '0;
         acc     <= '0;
         mplier  <= '0;
         iter    <= '0;
         res_neg <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand   <= PW'(mag_a);
                  mplier  <= mag_b;
                  acc     <= '0;
                  iter    <= CW'(ITER);
                  res_neg <= a_neg ^ b_neg;
               end
            end
            BUSY: begin
               acc    <= acc_nxt;
               mcand  <= mcand << BITS_PER_CYCLE;
               mplier <= mplier >> BITS_PER_CYCLE;
               iter   <= iter - CW'(1);
               if (last) result <= signed_w[RESULT_WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   assign mul_result = result;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed handshake/flush/reset scenarios on an 8-bit instance
// plus a scoreboarded random sweep across widths and digit sizes.
module tb_mul_iter;

   localparam int NCFG = 10;
   localparam int WS [NCFG] = '{8, 8, 8, 16, 16, 16, 32, 32, 32, 2};
   localparam int KS [NCFG] = '{1, 2, 4, 1, 2, 4, 1, 2, 4, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, flush;
   logic        in_valid, in_ready, a_signed, b_signed, out_valid, out_ready;
   logic [7:0]  A, B;
   logic [15:0] mul_result;

   logic        q_valid, q_ready, q_ovalid, q_ordy;
   logic [7:0]  qa, qb;
   logic [15:0] q_res;

   logic            sw_valid, sw_ordy, sw_as, sw_bs;
   logic [31:0]     sw_a, sw_b;
   logic [NCFG-1:0] sw_ir, sw_ov;
   logic [63:0]     sw_res [NCFG];

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q [$];
   logic [63:0] sw_q [NCFG][$];

   mul_iter #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .a_signed(a_signed), .b_signed(b_signed),
      .out_valid(out_valid), .out_ready(out_ready), .mul_result(mul_result)
   );

   mul_iter #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(q_valid), .in_ready(q_ready),
      .A(qa), .B(qb), .a_signed(1'b0), .b_signed(1'b0),
      .out_valid(q_ovalid), .out_ready(q_ordy), .mul_result(q_res)
   );

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_sw
      localparam int W = WS[gi];
      logic [2*W-1:0] res;
      logic           ir, ov;
      mul_iter #(.WIDTH(W), .BITS_PER_CYCLE(KS[gi])) u (
         .clk(clk), .rst_n(rst_n), .flush(1'b0),
         .in_valid(sw_valid), .in_ready(ir),
         .A(sw_a[W-1:0]), .B(sw_b[W-1:0]), .a_signed(sw_as), .b_signed(sw_bs),
         .out_valid(ov), .out_ready(sw_ordy), .mul_result(res)
      );
      assign sw_ir[gi]  = ir;
      assign sw_ov[gi]  = ov;
      assign sw_res[gi] = 64'(res);
   end

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic as, input logic bs, input int w);
      logic [63:0] m, ea, eb, rm;
      m  = (64'd1 << w) - 64'd1;
      ea = {32'b0, a} & m;
      eb = {32'b0, b} & m;
      if (as && ea[w-1]) ea = ea | ~m;
      if (bs && eb[w-1]) eb = eb | ~m;
      rm = (2 * w == 64) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
      return (ea * eb) & rm;
   endfunction

   // Drives one operand set through its accepting edge and records the expected product.
   task automatic start(input logic [7:0] a, input logic [7:0] b, input logic as,
                        input logic bs, input logic [63:0] expv);
      A = a; B = b; a_signed = as; b_signed = bs; in_valid = 1'b1;
      exp_q.push_back(expv);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 40);
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      logic [63:0] e;
      #12;
      checks++;
      if (out_valid !== 1'b0 || mul_result !== 16'h0) begin
         errors++;
         $display("FAIL reset_state out_valid=%b mul_result=%h exp 0/0000", out_valid, mul_result);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      start(8'd13, 8'd11, 1'b0, 1'b0, 64'h008F);
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL first_accept_latency got=%0d exp=8", lat);
      end
      checks++;
      if (mul_result !== e[15:0]) begin
         errors++;
         $display("FAIL first_accept_result got=%h exp=%h", mul_result, e[15:0]);
      end
      retire();
   endtask

   task automatic test_basic();
      logic [7:0]  ta [6] = '{8'd13, 8'hFF, 8'h80, 8'hFF, 8'h7F, 8'h80};
      logic [7:0]  tb [6] = '{8'd11, 8'hFF, 8'h80, 8'hFF, 8'h81, 8'h03};
      logic        tas[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic        tbs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      // 0x7F * 0x81 signed is 127 * -127 = -16129
      logic [15:0] te [6] = '{16'h008F, 16'hFE01, 16'h4000, 16'hFF01, 16'hC0FF, 16'hFE80};
      int lat;
      logic [63:0] e;
      for (int i = 0; i < 6; i++) begin
         start(ta[i], tb[i], tas[i], tbs[i], 64'(te[i]));
         wait_done(lat);
         e = exp_q.pop_front();
         checks++;
         if (lat != 8 || mul_result !== e[15:0]) begin
            errors++;
            $display("FAIL basic_%0d got=%h lat=%0d exp=%h lat=8", i, mul_result, lat, e[15:0]);
         end
         retire();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_retire_%0d in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_hold();
      int lat;
      logic [63:0] e;
      start(8'h12, 8'h34, 1'b0, 1'b0, 64'h03A8);
      in_valid = 1'b1; A = 8'hFF; B = 8'h80; a_signed = 1'b1; b_signed = 1'b1;
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat != 8 || mul_result !== e[15:0]) begin
         errors++;
         $display("FAIL hold_result got=%h lat=%0d exp=%h lat=8", mul_result, lat, e[15:0]);
      end
      for (int c = 0; c < 5; c++) begin
         A = 8'($urandom); B = 8'($urandom);
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || mul_result !== e[15:0]) begin
            errors++;
            $display("FAIL hold_cycle_%0d ov=%b ir=%b res=%h exp 1/0/%h", c, out_valid, in_ready,
                     mul_result, e[15:0]);
         end
      end
      in_valid = 1'b0;
      retire();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_flush();
      int lat, seen;
      logic [63:0] e;
      start(8'h12, 8'h34, 1'b0, 1'b0, 64'h03A8);
      repeat (2) begin @(posedge clk); #1; end
      flush = 1'b1; in_valid = 1'b1; A = 8'd9; B = 8'd9;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_result !== 16'h0) begin
         errors++;
         $display("FAIL flush_state ir=%b ov=%b res=%h exp 1/0/0000", in_ready, out_valid, mul_result);
      end
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL flush_no_output got=%0d valid cycles exp=0", seen);
      end
      start(8'd3, 8'd5, 1'b0, 1'b0, 64'h000F);
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat != 8 || mul_result !== e[15:0]) begin
         errors++;
         $display("FAIL flush_next_op got=%h lat=%0d exp=%h lat=8", mul_result, lat, e[15:0]);
      end
      retire();
   endtask

   task automatic test_reset_mid();
      int lat, seen;
      logic [63:0] e;
      start(8'd13, 8'd11, 1'b0, 1'b0, 64'h008F);
      repeat (4) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_busy ov=%b ir=%b exp 0/1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_no_stale got=%0d valid cycles exp=0", seen);
      end
      start(8'hFF, 8'hFF, 1'b0, 1'b0, 64'hFE01);
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if (mul_result !== e[15:0]) begin
         errors++;
         $display("FAIL reset_pre_done got=%h exp=%h", mul_result, e[15:0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (mul_result !== 16'h0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_done_async res=%h ov=%b exp 0000/0", mul_result, out_valid);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_k4();
      int lat;
      logic [63:0] e;
      qa = 8'hFF; qb = 8'hFF; q_valid = 1'b1;
      exp_q.push_back(64'hFE01);
      @(posedge clk); #1;
      q_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!q_ovalid && lat < 20);
      e = exp_q.pop_front();
      checks++;
      if (lat != 2 || q_res !== e[15:0]) begin
         errors++;
         $display("FAIL k4_run got=%h lat=%0d exp=%h lat=2", q_res, lat, e[15:0]);
      end
      q_ordy = 1'b1;
      @(posedge clk); #1;
      q_ordy = 1'b0;
   endtask

   task automatic test_sweep();
      int          done_cnt [NCFG];
      logic [63:0] ev;
      int          p;
      for (int i = 0; i < NCFG; i++) done_cnt[i] = 0;
      // ITER=1 instance must finish one edge after accept while wider ones are still busy
      sw_valid = 1'b1; sw_a = 32'd3; sw_b = 32'd3; sw_as = 1'b0; sw_bs = 1'b0; sw_ordy = 1'b0;
      @(posedge clk); #1;
      sw_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (sw_ov[9] !== 1'b1 || sw_res[9] !== 64'd9 || sw_ov[0] !== 1'b0) begin
         errors++;
         $display("FAIL iter1_latency ov=%b res=%h ov8=%b exp 1/9/0", sw_ov[9], sw_res[9], sw_ov[0]);
      end
      sw_ordy = 1'b1;
      repeat (40) @(posedge clk);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk); #1;
         p = $urandom_range(0, 9);
         sw_a = (p == 0) ? 32'hFFFF_FFFF : (p == 1) ? 32'h8000_0000 : (p == 2) ? 32'h0000_8000 :
                (p == 3) ? 32'h0000_0080 : (p == 4) ? 32'h0000_0002 : $urandom;
         p = $urandom_range(0, 9);
         sw_b = (p == 0) ? 32'hFFFF_FFFF : (p == 1) ? 32'h8000_0000 : (p == 2) ? 32'h0000_8000 :
                (p == 3) ? 32'h0000_0080 : (p == 4) ? 32'h0000_0002 : $urandom;
         sw_as    = 1'($urandom_range(0, 1));
         sw_bs    = 1'($urandom_range(0, 1));
         sw_valid = ($urandom_range(0, 3) != 0);
         sw_ordy  = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         for (int i = 0; i < NCFG; i++) begin
            if (sw_ov[i] && sw_ordy) begin
               checks++;
               if (sw_q[i].size() == 0) begin
                  errors++;
                  $display("FAIL sweep_cfg%0d unexpected result %h", i, sw_res[i]);
               end else begin
                  ev = sw_q[i].pop_front();
                  done_cnt[i]++;
                  if (sw_res[i] !== ev) begin
                     errors++;
                     $display("FAIL sweep_cfg%0d got=%h exp=%h", i, sw_res[i], ev);
                  end
               end
            end
            if (sw_ir[i] && sw_valid) sw_q[i].push_back(ref_mul(sw_a, sw_b, sw_as, sw_bs, WS[i]));
         end
      end
      sw_valid = 1'b0;
      for (int i = 0; i < NCFG; i++) begin
         checks++;
         if (done_cnt[i] < 5) begin
            errors++;
            $display("FAIL sweep_progress_cfg%0d got=%0d results exp>=5", i, done_cnt[i]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; a_signed = 1'b0; b_signed = 1'b0;
      q_valid = 1'b0; q_ordy = 1'b0; qa = '0; qb = '0;
      sw_valid = 1'b0; sw_ordy = 1'b0; sw_as = 1'b0; sw_bs = 1'b0; sw_a = '0; sw_b = '0;
      test_reset();
      test_basic();
      test_hold();
      test_flush();
      test_reset_mid();
      test_k4();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
